// File: rtl/nand_test_pkg.sv
// Shared types and constants for the NAND cell self-test sequencer.
package nand_test_pkg;

  localparam int VEC_W = 2;

  // Indexed by vec = {a,b}: expected ~(a&b) for 00,01,10,11.
  localparam logic [3:0] NAND_TT = 4'b0111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    FIN    = 2'd3
  } state_t;

endpackage

// File: rtl/nand_selftest_seq_settle_timer.sv
// Dwell timer: load arms COUNT cycles, expire is high in the last of them.
// No handshake; load has priority over counting.
module settle_timer #(
  parameter int COUNT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);

  localparam int W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [W-1:0] LOAD_VAL = W'(COUNT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/nand_selftest_seq.sv
// Truth-table sweep of a 2-input NAND cell with settle dwell and error tracking.
// start->done latency is 1 + 4*ITERATIONS*(SETTLE_CYCLES+1) cycles; start ignored while running.
module nand_selftest_seq
  import nand_test_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ITERATIONS    = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             dut_a,
  output logic             dut_b,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [VEC_W-1:0] first_fail_vec
);

  localparam int SW_W = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam logic [SW_W-1:0] LAST_SWEEP = SW_W'(ITERATIONS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
  localparam logic [VEC_W-1:0] VEC_LAST = {VEC_W{1'b1}};

  state_t           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [SW_W-1:0]  sweep_q, sweep_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fail_q, fail_d;
  logic [VEC_W-1:0] ffv_q, ffv_d;
  logic             pass_q, pass_d;
  logic             timer_load;
  logic             timer_expire;
  logic             mismatch;

  settle_timer #(
    .COUNT (SETTLE_CYCLES)
  ) u_settle (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .expire (timer_expire)
  );

  // Case inequality so an undriven or unknown cell output is a failure.
  assign mismatch = (dut_out !== NAND_TT[vec_q]);

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    sweep_d    = sweep_q;
    err_d      = err_q;
    fail_d     = fail_q;
    ffv_d      = ffv_q;
    pass_d     = pass_q;
    timer_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          err_d      = '0;
          fail_d     = 1'b0;
          ffv_d      = '0;
          pass_d     = 1'b0;
          vec_d      = '0;
          sweep_d    = '0;
          timer_load = 1'b1;
          state_d    = DRIVE;
        end
      end
      DRIVE: begin
        if (timer_expire) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (mismatch) begin
          if (err_q != ERR_MAX) begin
            err_d = err_q + ERR_W'(1);
          end
          if (!fail_q) begin
            fail_d = 1'b1;
            ffv_d  = vec_q;
          end
        end
        if ((vec_q == VEC_LAST) && (sweep_q == LAST_SWEEP)) begin
          // err_d already includes this final comparison.
          pass_d  = (err_d == '0);
          state_d = FIN;
        end else begin
          if (vec_q == VEC_LAST) begin
            sweep_d = sweep_q + SW_W'(1);
          end
          vec_d      = vec_q + VEC_W'(1);
          timer_load = 1'b1;
          state_d    = DRIVE;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      sweep_q <= '0;
      err_q   <= '0;
      fail_q  <= 1'b0;
      ffv_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      sweep_q <= sweep_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      ffv_q   <= ffv_d;
      pass_q  <= pass_d;
    end
  end

  assign busy           = (state_q == DRIVE) || (state_q == SAMPLE);
  assign done           = (state_q == FIN);
  assign dut_a          = busy & vec_q[1];
  assign dut_b          = busy & vec_q[0];
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign fail_valid     = fail_q;
  assign first_fail_vec = ffv_q;

endmodule

// File: tb/tb_nand_selftest_seq.sv
// Bench for nand_selftest_seq: default instance plus a 100-sweep instance for saturation.
module tb_nand_selftest_seq;
  import nand_test_pkg::*;

  localparam int S  = 2;
  localparam int I1 = 100;

  typedef struct {
    int         lat;
    logic [7:0] err;
    logic       fail;
    logic [1:0] ffv;
    logic       pass;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start0, start1;
  logic       a0, b0, busy0, done0, pass0, fv0, out0;
  logic       a1, b1, busy1, done1, pass1, fv1, out1;
  logic [7:0] err0, err1;
  logic [1:0] ffv0, ffv1;
  int         mode0, mode1;   // 0 good cell, 1 stuck-1, 2 stuck-0, 3 Z
  logic       zval = 1'bz;

  int checks = 0;
  int passes = 0;
  res_t sb[$];

  always_comb begin
    case (mode0)
      1:       out0 = 1'b1;
      2:       out0 = 1'b0;
      3:       out0 = zval;
      default: out0 = ~(a0 & b0);
    endcase
  end

  always_comb begin
    case (mode1)
      1:       out1 = 1'b1;
      2:       out1 = 1'b0;
      3:       out1 = zval;
      default: out1 = ~(a1 & b1);
    endcase
  end

  nand_selftest_seq #(.SETTLE_CYCLES(S), .ITERATIONS(1), .ERR_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .dut_a(a0), .dut_b(b0), .dut_out(out0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_valid(fv0), .first_fail_vec(ffv0)
  );

  nand_selftest_seq #(.SETTLE_CYCLES(S), .ITERATIONS(I1), .ERR_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .dut_a(a1), .dut_b(b1), .dut_out(out1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fv1), .first_fail_vec(ffv1)
  );

  function automatic res_t model(input int mode, input int iters);
    res_t r;
    logic e, o;
    r.lat  = 1 + 4 * iters * (S + 1);
    r.err  = '0;
    r.fail = 1'b0;
    r.ffv  = '0;
    for (int sw = 0; sw < iters; sw++) begin
      for (int v = 0; v < 4; v++) begin
        e = (v != 3);
        case (mode)
          1:       o = 1'b1;
          2:       o = 1'b0;
          3:       o = 1'bz;
          default: o = e;
        endcase
        if (o !== e) begin
          if (r.err != 8'hFF) r.err = r.err + 8'd1;
          if (!r.fail) begin
            r.fail = 1'b1;
            r.ffv  = 2'(v);
          end
        end
      end
    end
    r.pass = (r.err == 8'd0);
    return r;
  endfunction

  // Drives one start pulse and observes until done; restart_at re-pulses start mid-run.
  task automatic run_once(input int which, input int restart_at, input int budget,
                          output res_t obs, output int vec_bad, output int busy_bad);
    int n;
    logic [1:0] ab, ev;
    obs.lat = -1; obs.err = '0; obs.fail = 1'b0; obs.ffv = '0; obs.pass = 1'b0;
    vec_bad = 0; busy_bad = 0;
    @(negedge clk);
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    n = 1;
    while (n <= budget) begin
      if ((which == 0) ? done0 : done1) begin
        obs.lat  = n;
        obs.err  = (which == 0) ? err0 : err1;
        obs.fail = (which == 0) ? fv0 : fv1;
        obs.ffv  = (which == 0) ? ffv0 : ffv1;
        obs.pass = (which == 0) ? pass0 : pass1;
        if ((which == 0) ? busy0 : busy1) busy_bad++;
        break;
      end
      if (!((which == 0) ? busy0 : busy1)) busy_bad++;
      ab = (which == 0) ? {a0, b0} : {a1, b1};
      ev = 2'(((n - 1) / (S + 1)) % 4);
      if (ab !== ev) vec_bad++;
      if (n == restart_at) begin
        if (which == 0) start0 = 1'b1; else start1 = 1'b1;
      end else begin
        start0 = 1'b0; start1 = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; mode0 = 0; mode1 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a0, b0, busy0, done0, pass0, fv0, err0, ffv0} !== 16'h0)
      $display("FAIL reset_dut0 got %h want 0000", {a0, b0, busy0, done0, pass0, fv0, err0, ffv0});
    else passes++;
    checks++;
    if ({a1, b1, busy1, done1, pass1, fv1, err1, ffv1} !== 16'h0)
      $display("FAIL reset_dut1 got %h want 0000", {a1, b1, busy1, done1, pass1, fv1, err1, ffv1});
    else passes++;
    rst = 1'b0;
  endtask

  task automatic test_correct();
    res_t e, o; int vb, bb;
    mode0 = 0;
    sb.push_back(model(0, 1));
    run_once(0, 0, 40, o, vb, bb);
    e = sb.pop_front();
    checks++; if (o.lat !== e.lat) $display("FAIL good_latency got %0d want %0d", o.lat, e.lat); else passes++;
    checks++; if (o.lat !== 13) $display("FAIL good_latency13 got %0d want 13", o.lat); else passes++;
    checks++; if (vb !== 0) $display("FAIL good_vectors got %0d bad cycles want 0", vb); else passes++;
    checks++; if (bb !== 0) $display("FAIL good_busy got %0d bad cycles want 0", bb); else passes++;
    checks++; if (o.pass !== e.pass) $display("FAIL good_pass got %b want %b", o.pass, e.pass); else passes++;
    checks++; if (o.err !== e.err) $display("FAIL good_err got %0d want %0d", o.err, e.err); else passes++;
    checks++; if (o.fail !== e.fail) $display("FAIL good_fail_valid got %b want %b", o.fail, e.fail); else passes++;
    @(negedge clk);
    checks++; if (done0 !== 1'b0) $display("FAIL good_done_width got %b want 0", done0); else passes++;
    checks++; if (pass0 !== 1'b1) $display("FAIL good_pass_hold got %b want 1", pass0); else passes++;
  endtask

  task automatic test_stuck(input int mode, input string tag);
    res_t e, o; int vb, bb;
    mode0 = mode;
    sb.push_back(model(mode, 1));
    run_once(0, 0, 40, o, vb, bb);
    e = sb.pop_front();
    checks++; if (o.lat !== e.lat) $display("FAIL %s_latency got %0d want %0d", tag, o.lat, e.lat); else passes++;
    checks++; if (o.err !== e.err) $display("FAIL %s_err got %0d want %0d", tag, o.err, e.err); else passes++;
    checks++; if (o.fail !== e.fail) $display("FAIL %s_fail_valid got %b want %b", tag, o.fail, e.fail); else passes++;
    checks++; if (o.ffv !== e.ffv) $display("FAIL %s_first_vec got %b want %b", tag, o.ffv, e.ffv); else passes++;
    checks++; if (o.pass !== e.pass) $display("FAIL %s_pass got %b want %b", tag, o.pass, e.pass); else passes++;
    mode0 = 0;
  endtask

  task automatic test_stuck_z();
    // Z is only representable when the simulator is four-state.
    if (zval === 1'bz) test_stuck(3, "stuckz");
  endtask

  task automatic test_saturate();
    res_t e, o; int vb, bb;
    mode1 = 2;
    sb.push_back(model(2, I1));
    run_once(1, 0, 1300, o, vb, bb);
    e = sb.pop_front();
    checks++; if (o.lat !== e.lat) $display("FAIL sat_latency got %0d want %0d", o.lat, e.lat); else passes++;
    checks++; if (o.err !== 8'd255) $display("FAIL sat_err got %0d want 255", o.err); else passes++;
    checks++; if (o.ffv !== e.ffv) $display("FAIL sat_first_vec got %b want %b", o.ffv, e.ffv); else passes++;
    checks++; if (vb !== 0) $display("FAIL sat_vectors got %0d bad cycles want 0", vb); else passes++;
    mode1 = 0;
  endtask

  task automatic test_restart_busy();
    res_t e, o; int vb, bb;
    mode0 = 0;
    sb.push_back(model(0, 1));
    run_once(0, 5, 40, o, vb, bb);
    e = sb.pop_front();
    checks++; if (o.lat !== e.lat) $display("FAIL restart_latency got %0d want %0d", o.lat, e.lat); else passes++;
    checks++; if (vb !== 0) $display("FAIL restart_vectors got %0d bad cycles want 0", vb); else passes++;
    checks++; if (o.pass !== 1'b1) $display("FAIL restart_pass got %b want 1", o.pass); else passes++;
  endtask

  task automatic test_reset_mid();
    int dones;
    mode0 = 2;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    // Cycles 1..5: DRIVE 00, DRIVE 00, SAMPLE 00, DRIVE 01, DRIVE 01.
    repeat (4) @(negedge clk);
    checks++;
    if ({busy0, fv0, err0} !== {1'b1, 1'b1, 8'd1})
      $display("FAIL midrun_pre got %b/%b/%0d want 1/1/1", busy0, fv0, err0);
    else passes++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({a0, b0, busy0, done0, pass0, fv0, err0, ffv0} !== 16'h0)
      $display("FAIL midrun_reset got %h want 0000", {a0, b0, busy0, done0, pass0, fv0, err0, ffv0});
    else passes++;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done0 || busy0) dones++;
    end
    checks++; if (dones !== 0) $display("FAIL midrun_nodone got %0d active cycles want 0", dones); else passes++;
    mode0 = 0;
  endtask

  task automatic test_fresh_after_reset();
    res_t e, o; int vb, bb;
    mode0 = 0;
    sb.push_back(model(0, 1));
    run_once(0, 0, 40, o, vb, bb);
    e = sb.pop_front();
    checks++; if (o.lat !== e.lat) $display("FAIL fresh_latency got %0d want %0d", o.lat, e.lat); else passes++;
    checks++; if (o.pass !== 1'b1) $display("FAIL fresh_pass got %b want 1", o.pass); else passes++;
    checks++; if (o.err !== 8'd0) $display("FAIL fresh_err got %0d want 0", o.err); else passes++;
  endtask

  initial begin
    test_reset();
    test_correct();
    test_stuck(1, "stuck1");
    test_stuck(2, "stuck0");
    test_stuck_z();
    test_saturate();
    test_restart_busy();
    test_reset_mid();
    test_fresh_after_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
